// File: rtl/voting_booth_arbiter_if.sv
// Booth/tally signal bundle for voting_booth_arbiter.
// slave: the arbiter side. master: the booth/controller side.
// The audit counter outputs exist only when VOTE_AUDIT_EN is defined.
interface voting_booth_arbiter_if #(
   parameter int NUM_BOOTHS = 4,
   parameter int CAND_W     = 2
`ifdef VOTE_AUDIT_EN
   , parameter int CNT_W    = 16
`endif
);
   localparam int BOOTH_W = $clog2(NUM_BOOTHS);

   logic                         i_open;
   logic                         i_close;
   logic [NUM_BOOTHS-1:0]        i_req;
   logic [NUM_BOOTHS*CAND_W-1:0] i_cand;
   logic [NUM_BOOTHS-1:0]        o_ack;
   logic                         o_inc_valid;
   logic [CAND_W-1:0]            o_inc_cand;
   logic [BOOTH_W-1:0]           o_inc_booth;
   logic [1:0]                   o_state;
`ifdef VOTE_AUDIT_EN
   logic [CNT_W-1:0]             o_total;
   logic [CNT_W-1:0]             o_reject;
`endif

   modport slave (
      input  i_open, i_close, i_req, i_cand,
      output o_ack, o_inc_valid, o_inc_cand, o_inc_booth, o_state
`ifdef VOTE_AUDIT_EN
      , output o_total, o_reject
`endif
   );

   modport master (
      output i_open, i_close, i_req, i_cand,
      input  o_ack, o_inc_valid, o_inc_cand, o_inc_booth, o_state
`ifdef VOTE_AUDIT_EN
      , input o_total, o_reject
`endif
   );
endinterface

// File: rtl/voting_booth_arbiter.sv
// voting_booth_arbiter: session FSM plus round-robin arbiter sharing one tally
// increment port among NUM_BOOTHS booths. Each grant locks the booth for HOLDOFF
// cycles and disarms it until its request is seen low, so a held request counts once.
// Optional macro VOTE_AUDIT_EN adds saturating o_total / o_reject audit counters.
module voting_booth_arbiter #(
   parameter int NUM_BOOTHS = 4,
   parameter int NUM_CAND   = 3,
   parameter int CAND_W     = 2,
   parameter int HOLDOFF    = 16
`ifdef VOTE_AUDIT_EN
   , parameter int CNT_W    = 16
`endif
) (
   input logic                   clk,
   input logic                   rst,
   voting_booth_arbiter_if.slave bus
);
   localparam int BOOTH_W = $clog2(NUM_BOOTHS);
   localparam int LOCK_W  = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_CLOSED = 2'd3
   } state_t;

   state_t                state_reg;
   logic [BOOTH_W-1:0]    ptr_reg;
   logic [NUM_BOOTHS-1:0] ack_reg;
   logic                  inc_valid_reg;
   logic [CAND_W-1:0]     inc_cand_reg;
   logic [BOOTH_W-1:0]    inc_booth_reg;

   logic [NUM_BOOTHS-1:0] lock_zero;
   logic [NUM_BOOTHS-1:0] eligible;
   logic [NUM_BOOTHS-1:0] grant_onehot;
   logic                  grant_any;
   logic [BOOTH_W-1:0]    grant_idx;
   logic [CAND_W-1:0]     grant_cand;
   logic                  grant_cand_ok;
   logic                  all_quiet;

   // (base + off) modulo NUM_BOOTHS, with off < NUM_BOOTHS
   function automatic logic [BOOTH_W-1:0] rr_index(input logic [BOOTH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_BOOTHS) s = s - NUM_BOOTHS;
      return BOOTH_W'(s);
   endfunction

   generate
      for (genvar gi = 0; gi < NUM_BOOTHS; gi++) begin : g_booth
         logic [LOCK_W-1:0] lock_reg;
         logic              armed_reg;

         assign lock_zero[gi] = (lock_reg == '0);
         assign eligible[gi]  = (state_reg == ST_OPEN) && bus.i_req[gi] && lock_zero[gi] && armed_reg;

         // per-booth holdoff countdown and re-arm on a sampled-low request
         always_ff @(posedge clk) begin
            if (rst) begin
               lock_reg  <= '0;
               armed_reg <= 1'b1;
            end else if (grant_onehot[gi]) begin
               lock_reg  <= LOCK_W'(HOLDOFF);
               armed_reg <= 1'b0;
            end else begin
               if (!lock_zero[gi]) lock_reg <= lock_reg - 1'b1;
               if (!bus.i_req[gi]) armed_reg <= 1'b1;
            end
         end
      end
   endgenerate

   assign all_quiet = &lock_zero;

   // round-robin pick: scan from ptr downward-in-priority so the nearest offset wins
   always_comb begin
      grant_any    = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      for (int k = NUM_BOOTHS - 1; k >= 0; k--) begin
         if (eligible[rr_index(ptr_reg, k)]) begin
            grant_any = 1'b1;
            grant_idx = rr_index(ptr_reg, k);
         end
      end
      if (grant_any) grant_onehot[grant_idx] = 1'b1;
   end

   assign grant_cand    = bus.i_cand[grant_idx*CAND_W +: CAND_W];
   assign grant_cand_ok = (int'(grant_cand) < NUM_CAND);

   // session FSM with registered grant outputs and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         ack_reg       <= '0;
         inc_valid_reg <= 1'b0;
         inc_cand_reg  <= '0;
         inc_booth_reg <= '0;
      end else begin
         ack_reg       <= grant_onehot;
         inc_valid_reg <= grant_any && grant_cand_ok;
         inc_cand_reg  <= (grant_any && grant_cand_ok) ? grant_cand : '0;
         inc_booth_reg <= grant_any ? grant_idx : '0;
         if (grant_any) ptr_reg <= rr_index(grant_idx, 1);
         case (state_reg)
            ST_IDLE: begin
               if (bus.i_close)     state_reg <= ST_CLOSED;
               else if (bus.i_open) state_reg <= ST_OPEN;
            end
            ST_OPEN: begin
               if (bus.i_close) state_reg <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (all_quiet) state_reg <= ST_CLOSED;
            end
            default: state_reg <= ST_CLOSED;
         endcase
      end
   end

   assign bus.o_ack       = ack_reg;
   assign bus.o_inc_valid = inc_valid_reg;
   assign bus.o_inc_cand  = inc_cand_reg;
   assign bus.o_inc_booth = inc_booth_reg;
   assign bus.o_state     = state_reg;

`ifdef VOTE_AUDIT_EN
   logic [CNT_W-1:0] total_reg;
   logic [CNT_W-1:0] reject_reg;

   // saturating audit counters, updated alongside the grant and frozen once closed
   always_ff @(posedge clk) begin
      if (rst) begin
         total_reg  <= '0;
         reject_reg <= '0;
      end else if (grant_any && state_reg != ST_CLOSED) begin
         if (grant_cand_ok) begin
            if (total_reg != '1) total_reg <= total_reg + 1'b1;
         end else begin
            if (reject_reg != '1) reject_reg <= reject_reg + 1'b1;
         end
      end
   end

   assign bus.o_total  = total_reg;
   assign bus.o_reject = reject_reg;
`endif
endmodule

// File: tb/tb_voting_booth_arbiter.sv
// Self-checking bench for voting_booth_arbiter: directed session scenarios plus
// randomized request traffic, compared every cycle against a timestamp-based model.
module tb_voting_booth_arbiter;
   localparam int NB = 4;
   localparam int NC = 3;
   localparam int CW = 2;
   localparam int HO = 16;
   localparam int BW = 2;
`ifdef VOTE_AUDIT_EN
   localparam int CNT_W = 16;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voting_booth_arbiter_if #(
      .NUM_BOOTHS(NB), .CAND_W(CW)
`ifdef VOTE_AUDIT_EN
      , .CNT_W(CNT_W)
`endif
   ) vb_if ();

   voting_booth_arbiter #(
      .NUM_BOOTHS(NB), .NUM_CAND(NC), .CAND_W(CW), .HOLDOFF(HO)
`ifdef VOTE_AUDIT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(vb_if)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // reference model: per-booth grant timestamps instead of countdowns
   int  m_state;
   int  m_ptr;
   int  m_last  [NB];
   bit  m_used  [NB];
   bit  m_rearm [NB];
   int  e_total, e_reject;
   logic [NB-1:0] e_ack;
   logic          e_v;
   logic [CW-1:0] e_c;
   logic [BW-1:0] e_b;
   logic [1:0]    e_state;

   // observation log
   int ack_cnt [NB];
   int ack_cyc [NB];
   int last_valid, last_cand;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
   endtask

   function automatic bit quiet(input int b);
      return !m_used[b] || (cyc - m_last[b] > HO);
   endfunction

   task automatic model_edge();
      int g;
      int cand;
      bit all_q;
      g = -1;
      e_ack = '0; e_v = 1'b0; e_c = '0; e_b = '0;
      if (rst) begin
         m_state = 0; m_ptr = 0; e_total = 0; e_reject = 0;
         for (int b = 0; b < NB; b++) begin
            m_used[b] = 1'b0; m_rearm[b] = 1'b1;
         end
      end else begin
         if (m_state == 1) begin
            for (int k = 0; k < NB; k++) begin
               int b;
               b = (m_ptr + k) % NB;
               if (g < 0 && vb_if.i_req[b] && m_rearm[b] && quiet(b)) g = b;
            end
         end
         all_q = 1'b1;
         for (int b = 0; b < NB; b++) if (!quiet(b)) all_q = 1'b0;
         for (int b = 0; b < NB; b++) if (b != g && !vb_if.i_req[b]) m_rearm[b] = 1'b1;
         if (g >= 0) begin
            cand = int'(vb_if.i_cand[g*CW +: CW]);
            e_ack[g] = 1'b1;
            e_b = g[BW-1:0];
            m_used[g] = 1'b1; m_last[g] = cyc; m_rearm[g] = 1'b0;
            m_ptr = (g + 1) % NB;
            if (cand < NC) begin
               e_v = 1'b1; e_c = cand[CW-1:0];
               if (e_total < 65535) e_total++;
            end else begin
               if (e_reject < 65535) e_reject++;
            end
         end
         case (m_state)
            0: if (vb_if.i_close) m_state = 3; else if (vb_if.i_open) m_state = 1;
            1: if (vb_if.i_close) m_state = 2;
            2: if (all_q) m_state = 3;
            default: m_state = 3;
         endcase
      end
      e_state = m_state[1:0];
      cyc++;
   endtask

   // one clock: predict, advance, compare
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_eq("state", 32'(vb_if.o_state), 32'(e_state));
      check_eq("ack", 32'(vb_if.o_ack), 32'(e_ack));
      check_eq("inc_valid", 32'(vb_if.o_inc_valid), 32'(e_v));
      check_eq("inc_cand", 32'(vb_if.o_inc_cand), 32'(e_c));
      check_eq("inc_booth", 32'(vb_if.o_inc_booth), 32'(e_b));
`ifdef VOTE_AUDIT_EN
      check_eq("total", 32'(vb_if.o_total), e_total);
      check_eq("reject", 32'(vb_if.o_reject), e_reject);
`endif
      for (int b = 0; b < NB; b++) begin
         if (vb_if.o_ack[b]) begin
            ack_cnt[b]++;
            ack_cyc[b] = cyc;
            last_valid = int'(vb_if.o_inc_valid);
            last_cand  = int'(vb_if.o_inc_cand);
            $display("cyc=%0d ack booth=%0d valid=%0d cand=%0d state=%0d",
                     cyc, b, vb_if.o_inc_valid, vb_if.o_inc_cand, vb_if.o_state);
         end
      end
   endtask

   task automatic clear_inputs();
      vb_if.i_open = 1'b0; vb_if.i_close = 1'b0;
      vb_if.i_req = '0; vb_if.i_cand = '0;
   endtask

   task automatic clear_log();
      for (int b = 0; b < NB; b++) begin
         ack_cnt[b] = 0; ack_cyc[b] = -1;
      end
      last_valid = -1; last_cand = -1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1; step(); step();
      rst = 1'b0;
      clear_log();
   endtask

   task automatic open_session();
      vb_if.i_open = 1'b1; step(); vb_if.i_open = 1'b0;
   endtask

   task automatic set_cand(input int b, input int c);
      logic [CW-1:0] cv;
      cv = c[CW-1:0];
      vb_if.i_cand[b*CW +: CW] = cv;
   endtask

   initial begin
      int t0;
      int closed_at;
      int total_acks;
      clear_inputs();
      clear_log();

      // 1: single held request counted once
      do_reset();
      check_eq("rst_state", 32'(vb_if.o_state), 0);
      check_eq("rst_ack", 32'(vb_if.o_ack), 0);
      open_session();
      set_cand(1, 2); vb_if.i_req[1] = 1'b1; t0 = cyc;
      repeat (40) step();
      vb_if.i_req[1] = 1'b0; step();
      check_eq("s1_ack_count", ack_cnt[1], 1);
      check_eq("s1_ack_time", ack_cyc[1], t0 + 1);
      check_eq("s1_cand", last_cand, 2);

      // 2: simultaneous requests served in round-robin order
      do_reset();
      open_session();
      vb_if.i_req = '1; t0 = cyc;
      repeat (6) step();
      vb_if.i_req = '0; step();
      for (int b = 0; b < NB; b++) begin
         check_eq("s2_order", ack_cyc[b], t0 + 1 + b);
         check_eq("s2_count", ack_cnt[b], 1);
      end

      // 3: re-request during holdoff waits for lock expiry
      do_reset();
      open_session();
      vb_if.i_req[0] = 1'b1; t0 = cyc;
      step();
      vb_if.i_req[0] = 1'b0;
      repeat (4) step();
      vb_if.i_req[0] = 1'b1;
      repeat (20) step();
      vb_if.i_req[0] = 1'b0; step();
      check_eq("s3_count", ack_cnt[0], 2);
      check_eq("s3_gap", ack_cyc[0] - (t0 + 1), 17);

      // 4: invalid candidate acked but not counted
      do_reset();
      open_session();
      set_cand(2, 3); vb_if.i_req[2] = 1'b1;
      step();
      vb_if.i_req[2] = 1'b0;
      repeat (2) step();
      check_eq("s4_ack", ack_cnt[2], 1);
      check_eq("s4_valid", last_valid, 0);
`ifdef VOTE_AUDIT_EN
      check_eq("s4_reject", 32'(vb_if.o_reject), 1);
      check_eq("s4_total", 32'(vb_if.o_total), 0);
`endif

      // 5: close coincident with a request; drain then closed
      do_reset();
      open_session();
      set_cand(3, 1); vb_if.i_req[3] = 1'b1; vb_if.i_close = 1'b1; t0 = cyc;
      step();
      vb_if.i_close = 1'b0;
      check_eq("s5_state", 32'(vb_if.o_state), 2);
      check_eq("s5_ack3", ack_cyc[3], t0 + 1);
      vb_if.i_req = '1;
      closed_at = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (closed_at < 0 && vb_if.o_state == 2'd3) closed_at = cyc;
      end
      check_eq("s5_drain_len", closed_at - (t0 + 1), 17);
      total_acks = 0;
      for (int b = 0; b < NB; b++) total_acks += ack_cnt[b];
      check_eq("s5_total_acks", total_acks, 1);

      // 6: reset mid-session, then open+close together
      do_reset();
      open_session();
      vb_if.i_req = '1;
      repeat (2) step();
      rst = 1'b1; step();
      check_eq("s6_state", 32'(vb_if.o_state), 0);
      check_eq("s6_ack", 32'(vb_if.o_ack), 0);
      rst = 1'b0; vb_if.i_req = '0;
      vb_if.i_open = 1'b1; vb_if.i_close = 1'b1; step();
      vb_if.i_open = 1'b0; vb_if.i_close = 1'b0;
      check_eq("s6_closed", 32'(vb_if.o_state), 3);
      step();

      // randomized sessions
      for (int s = 0; s < 6; s++) begin
         do_reset();
         open_session();
         for (int c = 0; c < 180; c++) begin
            for (int b = 0; b < NB; b++)
               if ($urandom_range(0, 3) == 0) vb_if.i_req[b] = ~vb_if.i_req[b];
            vb_if.i_cand = NB*CW'($urandom);
            vb_if.i_open = ($urandom_range(0, 15) == 0);
            vb_if.i_close = (c == 150);
            rst = (s == 3 && c == 90);
            step();
         end
         rst = 1'b0;
         clear_inputs();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
